// File: rtl/conv_operand_loader.sv
// conv_operand_loader: assembles a serial byte stream into the 4x4 input and 3x3 filter
// buses of the 2x2 systolic convolution array and sequences the array's reset/run/done.
module conv_operand_loader #(
    parameter int DATA_W     = 8,
    parameter int RST_CYCLES = 2,
    parameter int RUN_CYCLES = 20
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    input  logic [DATA_W-1:0]     s_data,
    output logic                  s_ready,
    output logic [16*DATA_W-1:0]  in_mat,
    output logic [9*DATA_W-1:0]   flt_mat,
    output logic                  arr_rst,
    output logic                  done
);
    typedef enum logic [2:0] {IDLE, LOAD, ARR_RST, RUN, DONE} state_t;

    localparam logic [4:0] RST_LAST = 5'(RST_CYCLES - 1);
    localparam logic [4:0] RUN_LAST = 5'(RUN_CYCLES - 1);

    state_t            state_q;
    logic [4:0]        cnt_q, tmr_q, wr_idx_d;
    logic              s_ready_q, arr_rst_q, done_q, xfer_d;
    logic [DATA_W-1:0] in_q  [16];
    logic [DATA_W-1:0] flt_q [9];

    // Transfer strobe and the byte slot it targets; a frame always restarts at slot 0.
    always_comb begin
        xfer_d   = s_valid && s_ready_q;
        wr_idx_d = (state_q == LOAD) ? cnt_q : 5'd0;
    end

    // Sequencer: byte count, reset/run timers and registered handshake/array controls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= 5'd0;
            tmr_q     <= 5'd0;
            s_ready_q <= 1'b0;
            arr_rst_q <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    s_ready_q <= 1'b1;
                    arr_rst_q <= 1'b1;
                    done_q    <= 1'b0;
                    if (xfer_d) begin
                        cnt_q   <= 5'd1;
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    if (cnt_q > 5'd24) begin
                        cnt_q   <= 5'd0;
                        state_q <= IDLE;
                    end else if (xfer_d) begin
                        if (cnt_q == 5'd24) begin
                            cnt_q     <= 5'd0;
                            tmr_q     <= 5'd0;
                            s_ready_q <= 1'b0;
                            state_q   <= ARR_RST;
                        end else begin
                            cnt_q <= cnt_q + 5'd1;
                        end
                    end
                end
                ARR_RST: begin
                    if (tmr_q >= RST_LAST) begin
                        tmr_q     <= 5'd0;
                        arr_rst_q <= 1'b0;
                        state_q   <= RUN;
                    end else begin
                        tmr_q <= tmr_q + 5'd1;
                    end
                end
                RUN: begin
                    if (tmr_q >= RUN_LAST) begin
                        tmr_q     <= 5'd0;
                        done_q    <= 1'b1;
                        s_ready_q <= 1'b1;
                        state_q   <= DONE;
                    end else begin
                        tmr_q <= tmr_q + 5'd1;
                    end
                end
                DONE: begin
                    if (xfer_d) begin
                        cnt_q     <= 5'd1;
                        done_q    <= 1'b0;
                        arr_rst_q <= 1'b1;
                        state_q   <= LOAD;
                    end
                end
                default: begin
                    cnt_q   <= 5'd0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Operand storage: slots 0..15 are the input matrix, 16..24 the filter (low 4 bits index it).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 16; k++) in_q[k] <= '0;
            for (int k = 0; k < 9; k++) flt_q[k] <= '0;
        end else if (xfer_d) begin
            if (wr_idx_d < 5'd16) in_q[wr_idx_d[3:0]] <= s_data;
            else if (wr_idx_d <= 5'd24) flt_q[wr_idx_d[3:0]] <= s_data;
        end
    end

    for (genvar i = 0; i < 16; i++) begin : g_in
        assign in_mat[i*DATA_W +: DATA_W] = in_q[i];
    end
    for (genvar i = 0; i < 9; i++) begin : g_flt
        assign flt_mat[i*DATA_W +: DATA_W] = flt_q[i];
    end

    assign s_ready = s_ready_q;
    assign arr_rst = arr_rst_q;
    assign done    = done_q;
endmodule

// File: tb/tb_conv_operand_loader.sv
// tb_conv_operand_loader: randomized frame loads checked against a byte-queue reference model.
module tb_conv_operand_loader;
    localparam int RC = 2;
    localparam int RN = 20;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         s_valid = 1'b0;
    logic [7:0]   s_data = 8'h00;
    logic         s_ready, arr_rst, done;
    logic [127:0] in_mat;
    logic [71:0]  flt_mat;

    int           checks = 0;
    int           failures = 0;
    logic [7:0]   frame [25];
    logic [127:0] exp_in = '0;
    logic [71:0]  exp_flt = '0;

    always #5 clk = ~clk;

    conv_operand_loader #(.DATA_W(8), .RST_CYCLES(RC), .RUN_CYCLES(RN)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .in_mat(in_mat), .flt_mat(flt_mat), .arr_rst(arr_rst), .done(done)
    );

    // Reference: byte k of a frame lands at i(k/4)(k%4) for k<16, else f((k-16)/3)((k-16)%3).
    function automatic void build_exp();
        for (int k = 0; k < 25; k++) begin
            if (k < 16) exp_in[8*k +: 8] = frame[k];
            else exp_flt[8*(k-16) +: 8] = frame[k];
        end
    endfunction

    task automatic send(input logic [7:0] b, input int gap);
        int n = 0;
        @(negedge clk);
        repeat (gap) @(negedge clk);
        s_valid = 1'b1;
        s_data  = b;
        while (!s_ready && n < 60) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (s_ready !== 1'b1) begin
            failures++;
            $display("FAIL send_timeout s_ready=%b required 1", s_ready);
        end
        @(posedge clk);
        #1 s_valid = 1'b0;
    endtask

    task automatic send_range(input int lo, input int hi, input int maxgap);
        for (int k = lo; k <= hi; k++) send(frame[k], $urandom_range(0, maxgap));
    endtask

    task automatic wait_done(input bit offer_aa, output int low_at, output int done_at, output bit rdy_bad);
        low_at = -1;
        done_at = -1;
        rdy_bad = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (done) begin
                done_at = k;
                break;
            end
            if (!arr_rst && low_at < 0) low_at = k;
            if (s_ready) rdy_bad = 1'b1;
            s_valid = offer_aa && k < 15;
            s_data  = 8'hAA;
        end
        s_valid = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({s_ready, arr_rst, done} !== 3'b010) begin
            failures++;
            $display("FAIL reset_ctrl s_ready/arr_rst/done=%b required 010", {s_ready, arr_rst, done});
        end
        checks++;
        if (in_mat !== '0 || flt_mat !== '0) begin
            failures++;
            $display("FAIL reset_mats in=%h flt=%h required 0", in_mat, flt_mat);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (s_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_release_ready s_ready=%b required 0", s_ready);
        end
        @(negedge clk);
        checks++;
        if (s_ready !== 1'b1 || arr_rst !== 1'b1) begin
            failures++;
            $display("FAIL idle_ready s_ready=%b arr_rst=%b required 1 1", s_ready, arr_rst);
        end
    endtask

    task automatic test_full_frame();
        int lo, dn;
        bit rb;
        for (int k = 0; k < 25; k++) frame[k] = 8'(k + 1);
        build_exp();
        send_range(0, 24, 0);
        checks++;
        if (in_mat !== exp_in || flt_mat !== exp_flt) begin
            failures++;
            $display("FAIL full_mats in=%h flt=%h required in=%h flt=%h", in_mat, flt_mat, exp_in, exp_flt);
        end
        wait_done(1'b0, lo, dn, rb);
        checks++;
        if (lo != RC) begin
            failures++;
            $display("FAIL full_arr_rst_len got=%0d required %0d", lo, RC);
        end
        checks++;
        if (dn != RC + RN) begin
            failures++;
            $display("FAIL full_latency got=%0d required %0d", dn, RC + RN);
        end
        checks++;
        if (rb) begin
            failures++;
            $display("FAIL full_ready_busy s_ready seen 1 required 0");
        end
        checks++;
        if ({s_ready, arr_rst, done} !== 3'b101) begin
            failures++;
            $display("FAIL done_ctrl s_ready/arr_rst/done=%b required 101", {s_ready, arr_rst, done});
        end
    endtask

    task automatic test_gapped();
        int lo, dn;
        bit rb;
        for (int k = 0; k < 25; k++) frame[k] = 8'($urandom);
        build_exp();
        send_range(0, 24, 3);
        checks++;
        if (in_mat !== exp_in || flt_mat !== exp_flt) begin
            failures++;
            $display("FAIL gap_mats in=%h flt=%h required in=%h flt=%h", in_mat, flt_mat, exp_in, exp_flt);
        end
        wait_done(1'b1, lo, dn, rb);
        checks++;
        if (dn != RC + RN || lo != RC) begin
            failures++;
            $display("FAIL gap_timing low=%0d done=%0d required %0d %0d", lo, dn, RC, RC + RN);
        end
        checks++;
        if (rb) begin
            failures++;
            $display("FAIL gap_ready_busy s_ready seen 1 required 0");
        end
        checks++;
        if (in_mat !== exp_in || flt_mat !== exp_flt) begin
            failures++;
            $display("FAIL gap_ignored_aa in=%h flt=%h required in=%h flt=%h", in_mat, flt_mat, exp_in, exp_flt);
        end
    endtask

    task automatic test_end_to_end();
        int lo, dn, acc;
        bit rb;
        for (int k = 0; k < 25; k++) frame[k] = 8'd1;
        build_exp();
        send_range(0, 24, 1);
        wait_done(1'b0, lo, dn, rb);
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 2; c++) begin
                acc = 0;
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        acc += int'(in_mat[8*((r+i)*4 + c + j) +: 8]) * int'(flt_mat[8*(i*3 + j) +: 8]);
                checks++;
                if (acc != 9 || done !== 1'b1) begin
                    failures++;
                    $display("FAIL e2e_o%0d%0d got=%0d done=%b required 9 1", r, c, acc, done);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int lo, dn;
        logic [127:0] old_in;
        bit rb;
        old_in = exp_in;
        checks++;
        if (done !== 1'b1 || in_mat !== old_in) begin
            failures++;
            $display("FAIL b2b_old_results done=%b in=%h required 1 %h", done, in_mat, old_in);
        end
        for (int k = 0; k < 25; k++) frame[k] = 8'($urandom);
        send(frame[0], 0);
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || arr_rst !== 1'b1) begin
            failures++;
            $display("FAIL b2b_restart done=%b arr_rst=%b required 0 1", done, arr_rst);
        end
        checks++;
        if (in_mat !== {old_in[127:8], frame[0]}) begin
            failures++;
            $display("FAIL b2b_first_byte in=%h required %h", in_mat, {old_in[127:8], frame[0]});
        end
        send_range(1, 24, 0);
        build_exp();
        checks++;
        if (in_mat !== exp_in || flt_mat !== exp_flt) begin
            failures++;
            $display("FAIL b2b_mats in=%h flt=%h required in=%h flt=%h", in_mat, flt_mat, exp_in, exp_flt);
        end
        wait_done(1'b0, lo, dn, rb);
        checks++;
        if (dn != RC + RN) begin
            failures++;
            $display("FAIL b2b_latency got=%0d required %0d", dn, RC + RN);
        end
    endtask

    task automatic test_reset_mid_load();
        int lo, dn;
        bit rb;
        for (int k = 0; k < 25; k++) frame[k] = 8'($urandom);
        send_range(0, 9, 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({s_ready, arr_rst, done} !== 3'b010 || in_mat !== '0 || flt_mat !== '0) begin
            failures++;
            $display("FAIL mid_load_reset ctrl=%b in=%h flt=%h required 010 0 0", {s_ready, arr_rst, done}, in_mat, flt_mat);
        end
        @(negedge clk);
        rst = 1'b0;
        exp_in = '0;
        exp_flt = '0;
        for (int k = 0; k < 25; k++) frame[k] = 8'($urandom);
        build_exp();
        send_range(0, 24, 2);
        checks++;
        if (in_mat !== exp_in || flt_mat !== exp_flt) begin
            failures++;
            $display("FAIL reload_mats in=%h flt=%h required in=%h flt=%h", in_mat, flt_mat, exp_in, exp_flt);
        end
        wait_done(1'b0, lo, dn, rb);
        checks++;
        if (dn != RC + RN) begin
            failures++;
            $display("FAIL reload_latency got=%0d required %0d", dn, RC + RN);
        end
    endtask

    task automatic test_reset_mid_run();
        bit saw_bad = 1'b0;
        for (int k = 0; k < 25; k++) frame[k] = 8'($urandom);
        send_range(0, 24, 0);
        repeat (RC + 5) @(negedge clk);
        checks++;
        if (arr_rst !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL in_run arr_rst=%b done=%b required 0 0", arr_rst, done);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({s_ready, arr_rst, done} !== 3'b010 || in_mat !== '0) begin
            failures++;
            $display("FAIL mid_run_reset ctrl=%b in=%h required 010 0", {s_ready, arr_rst, done}, in_mat);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 40; k++) begin
            if (done || !arr_rst || !s_ready) saw_bad = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (saw_bad) begin
            failures++;
            $display("FAIL mid_run_no_done done/arr_rst/s_ready left idle values required 0 1 1");
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_gapped();
        test_end_to_end();
        test_back_to_back();
        test_reset_mid_load();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
